// File: rtl/wtr_arbiter_pkg.sv
// Shared processor definitions for the write-to-register path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wtr_arbiter_pkg;

  // Register select width and the highest legal select code (valid 1..WB_NUM_REGS).
  localparam int WB_SEL_W    = 5;
  localparam int WB_NUM_REGS = 14;
  localparam int WB_DATA_W   = 16;

  // Requester identities, also used as the last-grant flag encoding.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

endpackage

// File: rtl/wtr_arbiter.sv
// Round-robin arbiter merging ALU and memory-load write-backs onto one register-bank write port.
// Latency: ack is combinational in the request cycle; WTR_en/sel_err/WTR_sel/wtr_data appear one cycle later.
// Backpressure: wtr_stall (or reset) withholds every ack; requesters hold sel/data until acked.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   alu_req/alu_sel/alu_data       ALU write-back request, alu_ack consumes it
//   mem_req/mem_sel/mem_data       memory write-back request, mem_ack consumes it
//   wtr_stall                      blocks all grants while high
//   WTR_sel/WTR_en/wtr_data        registered write to the register bank
//   sel_err                        one-cycle pulse when a consumed request had an illegal select
module wtr_arbiter
  import wtr_arbiter_pkg::*;
#(
  parameter int DATA_W   = WB_DATA_W,
  parameter int SEL_W    = WB_SEL_W,
  parameter int NUM_REGS = WB_NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_req,
  input  logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ack,
  input  logic              mem_req,
  input  logic [SEL_W-1:0]  mem_sel,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ack,
  input  logic              wtr_stall,
  output logic [SEL_W-1:0]  WTR_sel,
  output logic              WTR_en,
  output logic [DATA_W-1:0] wtr_data,
  output logic              sel_err
);

  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(NUM_REGS);

  req_id_e           last_q, last_d;
  logic              en_q, en_d;
  logic              err_q, err_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              grant_alu, grant_mem;
  logic [SEL_W-1:0]  win_sel;
  logic [DATA_W-1:0] win_data;
  logic              win_valid;

  // Grant decision. rst_n is included so that no request is consumed while
  // reset is asserted; the requester must present it again afterwards.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (rst_n && !wtr_stall) begin
      if (alu_req && mem_req) begin
        // Contention: the side that did not win last time goes now.
        if (last_q == REQ_MEM) grant_alu = 1'b1;
        else                   grant_mem = 1'b1;
      end else if (alu_req) begin
        grant_alu = 1'b1;
      end else if (mem_req) begin
        grant_mem = 1'b1;
      end
    end
  end

  assign alu_ack = grant_alu;
  assign mem_ack = grant_mem;

  assign win_sel   = grant_mem ? mem_sel  : alu_sel;
  assign win_data  = grant_mem ? mem_data : alu_data;
  assign win_valid = (win_sel != '0) && (win_sel <= MAX_SEL);

  always_comb begin
    last_d = last_q;
    en_d   = 1'b0;
    err_d  = 1'b0;
    sel_d  = sel_q;
    data_d = data_q;
    if (grant_alu || grant_mem) begin
      last_d = grant_mem ? REQ_MEM : REQ_ALU;
      if (win_valid) begin
        en_d   = 1'b1;
        sel_d  = win_sel;
        data_d = win_data;
      end else begin
        // Illegal target: the request is still consumed, but the bus holds.
        err_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= REQ_MEM;
      en_q   <= 1'b0;
      err_q  <= 1'b0;
      sel_q  <= '0;
      data_q <= '0;
    end else begin
      last_q <= last_d;
      en_q   <= en_d;
      err_q  <= err_d;
      sel_q  <= sel_d;
      data_q <= data_d;
    end
  end

  assign WTR_en   = en_q;
  assign sel_err  = err_q;
  assign WTR_sel  = sel_q;
  assign wtr_data = data_q;

endmodule

// File: tb/tb_wtr_arbiter.sv
// Directed and randomized checks for the write-to-register arbiter.
// Latency: acks checked in the request cycle, writes one cycle later.
// Backpressure: stall and hold-until-ack requesters exercised.
module tb_wtr_arbiter;

  logic        clk;
  logic        rst_n;
  logic        alu_req, mem_req, wtr_stall;
  logic [4:0]  alu_sel, mem_sel;
  logic [15:0] alu_data, mem_data;
  logic        alu_ack, mem_ack;
  logic [4:0]  WTR_sel;
  logic        WTR_en, sel_err;
  logic [15:0] wtr_data;

  int checks = 0;
  int errors = 0;

  wtr_arbiter #(.DATA_W(16), .SEL_W(5), .NUM_REGS(14)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .alu_req  (alu_req),
    .alu_sel  (alu_sel),
    .alu_data (alu_data),
    .alu_ack  (alu_ack),
    .mem_req  (mem_req),
    .mem_sel  (mem_sel),
    .mem_data (mem_data),
    .mem_ack  (mem_ack),
    .wtr_stall(wtr_stall),
    .WTR_sel  (WTR_sel),
    .WTR_en   (WTR_en),
    .wtr_data (wtr_data),
    .sel_err  (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string nm, input logic en, input logic err,
                           input logic [4:0] sel, input logic [15:0] dat);
    chk({nm, "_en"},   32'(WTR_en),   32'(en));
    chk({nm, "_err"},  32'(sel_err),  32'(err));
    chk({nm, "_sel"},  32'(WTR_sel),  32'(sel));
    chk({nm, "_data"}, 32'(wtr_data), 32'(dat));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_req = 0; mem_req = 0; wtr_stall = 0;
    alu_sel = 0; mem_sel = 0; alu_data = 0; mem_data = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  // One row: inputs for a cycle, acks expected in that cycle, and the
  // registered outputs expected in that cycle (result of the previous row).
  typedef struct {
    logic        ar; logic [4:0] as; logic [15:0] ad;
    logic        mr; logic [4:0] ms; logic [15:0] md;
    logic        st;
    logic        ea; logic em;
    logic        een; logic eer; logic [4:0] esel; logic [15:0] edat;
  } vec_t;

  function automatic vec_t mk(logic ar, logic [4:0] as, logic [15:0] ad,
                              logic mr, logic [4:0] ms, logic [15:0] md, logic st,
                              logic ea, logic em, logic een, logic eer,
                              logic [4:0] esel, logic [15:0] edat);
    vec_t v;
    v.ar = ar; v.as = as; v.ad = ad; v.mr = mr; v.ms = ms; v.md = md; v.st = st;
    v.ea = ea; v.em = em; v.een = een; v.eer = eer; v.esel = esel; v.edat = edat;
    return v;
  endfunction

  vec_t tbl[14];

  // Random-phase state
  logic        a_pend, m_pend;
  logic        last_m;          // 0 = ALU granted last, 1 = MEM
  logic        x_en, x_err;
  logic [4:0]  x_sel;
  logic [15:0] x_data;
  logic        ga, gm;
  logic [4:0]  ws;
  logic [15:0] wd;
  int          max_ack_seen;

  initial begin
    //            ar as  ad       mr ms  md       st  ea em  en er sel data
    tbl[0]  = mk(1, 7,  16'h00A5, 0, 0,  16'h0000, 0,  1, 0,  0, 0, 0,  16'h0000);
    tbl[1]  = mk(0, 0,  16'h0000, 0, 0,  16'h0000, 0,  0, 0,  1, 0, 7,  16'h00A5);
    tbl[2]  = mk(1, 1,  16'h1111, 1, 2,  16'h2222, 0,  0, 1,  0, 0, 7,  16'h00A5);
    tbl[3]  = mk(1, 1,  16'h1111, 1, 2,  16'h2222, 0,  1, 0,  1, 0, 2,  16'h2222);
    tbl[4]  = mk(0, 0,  16'h0000, 1, 15, 16'hBEEF, 0,  0, 1,  1, 0, 1,  16'h1111);
    tbl[5]  = mk(0, 0,  16'h0000, 1, 0,  16'hCAFE, 0,  0, 1,  0, 1, 1,  16'h1111);
    tbl[6]  = mk(0, 0,  16'h0000, 0, 0,  16'h0000, 0,  0, 0,  0, 1, 1,  16'h1111);
    tbl[7]  = mk(1, 3,  16'h3333, 1, 4,  16'h4444, 1,  0, 0,  0, 0, 1,  16'h1111);
    tbl[8]  = mk(1, 3,  16'h3333, 1, 4,  16'h4444, 1,  0, 0,  0, 0, 1,  16'h1111);
    tbl[9]  = mk(1, 3,  16'h3333, 1, 4,  16'h4444, 1,  0, 0,  0, 0, 1,  16'h1111);
    tbl[10] = mk(1, 3,  16'h3333, 1, 4,  16'h4444, 0,  1, 0,  0, 0, 1,  16'h1111);
    tbl[11] = mk(0, 0,  16'h0000, 1, 4,  16'h4444, 0,  0, 1,  1, 0, 3,  16'h3333);
    tbl[12] = mk(1, 14, 16'h0E0E, 0, 0,  16'h0000, 0,  1, 0,  1, 0, 4,  16'h4444);
    tbl[13] = mk(0, 0,  16'h0000, 0, 0,  16'h0000, 0,  0, 0,  1, 0, 14, 16'h0E0E);

    // Reset state, including a request that must not be acked under reset.
    idle_inputs();
    rst_n = 0;
    alu_req = 1; alu_sel = 3; mem_req = 1; mem_sel = 4;
    #2;
    chk("rst_alu_ack", 32'(alu_ack), 0);
    chk("rst_mem_ack", 32'(mem_ack), 0);
    check_out("rst", 0, 0, 0, 0);
    step();
    idle_inputs();
    step();
    rst_n = 1;

    // Table-driven directed vectors.
    for (int i = 0; i < 14; i++) begin
      alu_req = tbl[i].ar; alu_sel = tbl[i].as; alu_data = tbl[i].ad;
      mem_req = tbl[i].mr; mem_sel = tbl[i].ms; mem_data = tbl[i].md;
      wtr_stall = tbl[i].st;
      @(negedge clk);
      chk($sformatf("row%0d_alu_ack", i), 32'(alu_ack), 32'(tbl[i].ea));
      chk($sformatf("row%0d_mem_ack", i), 32'(mem_ack), 32'(tbl[i].em));
      check_out($sformatf("row%0d", i), tbl[i].een, tbl[i].eer, tbl[i].esel, tbl[i].edat);
      step();
    end

    // Round-robin from reset: ALU, MEM, ALU, MEM with both held.
    do_reset();
    alu_req = 1; alu_sel = 1; alu_data = 16'h0101;
    mem_req = 1; mem_sel = 2; mem_data = 16'h0202;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rr%0d_alu_ack", k), 32'(alu_ack), 32'((k % 2) == 0));
      chk($sformatf("rr%0d_mem_ack", k), 32'(mem_ack), 32'((k % 2) == 1));
      if (k > 0) chk($sformatf("rr%0d_sel", k), 32'(WTR_sel), 32'(((k % 2) == 1) ? 1 : 2));
      step();
    end
    idle_inputs();
    @(negedge clk);
    check_out("rr_tail", 1, 0, 2, 16'h0202);
    step();

    // Reset in the middle of a write: outputs clear at once, ALU wins after.
    alu_req = 1; alu_sel = 5; alu_data = 16'h5555;
    @(negedge clk);
    chk("mid_alu_ack", 32'(alu_ack), 1);
    step();
    idle_inputs();
    alu_req = 1; alu_sel = 6; mem_req = 1; mem_sel = 8;
    @(negedge clk);
    check_out("mid_pre", 1, 0, 5, 16'h5555);
    #1 rst_n = 0;
    #1;
    check_out("mid_rst", 0, 0, 0, 0);
    chk("mid_rst_alu_ack", 32'(alu_ack), 0);
    chk("mid_rst_mem_ack", 32'(mem_ack), 0);
    step();
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_alu_ack", 32'(alu_ack), 1);
    chk("post_rst_mem_ack", 32'(mem_ack), 0);
    step();

    // Random traffic with hold-until-ack requesters and a reference model.
    do_reset();
    a_pend = 0; m_pend = 0; last_m = 1;
    x_en = 0; x_err = 0; x_sel = 0; x_data = 0;
    max_ack_seen = 0;
    for (int c = 0; c < 10000; c++) begin
      if (!a_pend && ($urandom_range(0, 1) == 1)) begin
        a_pend = 1; alu_sel = 5'($urandom_range(0, 31)); alu_data = 16'($urandom);
      end
      if (!m_pend && ($urandom_range(0, 1) == 1)) begin
        m_pend = 1; mem_sel = 5'($urandom_range(0, 31)); mem_data = 16'($urandom);
      end
      alu_req = a_pend;
      mem_req = m_pend;
      wtr_stall = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (WTR_en !== x_en || sel_err !== x_err || WTR_sel !== x_sel || wtr_data !== x_data)
        check_out($sformatf("rnd%0d", c), x_en, x_err, x_sel, x_data);
      else
        checks++;
      ga = 0; gm = 0;
      if (!wtr_stall) begin
        if (a_pend && m_pend) begin
          if (last_m) ga = 1; else gm = 1;
        end else begin
          ga = a_pend;
          gm = m_pend;
        end
      end
      if (alu_ack !== ga || mem_ack !== gm) begin
        chk($sformatf("rnd%0d_alu_ack", c), 32'(alu_ack), 32'(ga));
        chk($sformatf("rnd%0d_mem_ack", c), 32'(mem_ack), 32'(gm));
      end else begin
        checks++;
      end
      if (ga || gm) begin
        ws = gm ? mem_sel : alu_sel;
        wd = gm ? mem_data : alu_data;
        last_m = gm;
        if (ws != 0 && ws <= 14) begin
          x_en = 1; x_err = 0; x_sel = ws; x_data = wd;
        end else begin
          x_en = 0; x_err = 1;
        end
      end else begin
        x_en = 0; x_err = 0;
      end
      if (ga) a_pend = 0;
      if (gm) m_pend = 0;
      step();
    end
    idle_inputs();
    @(negedge clk);
    check_out("rnd_tail", x_en, x_err, x_sel, x_data);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
